burst_read_ram: RTL



---
 rtl/burst_read_ram.sv | 73 +++++++
 1 files changed

// File: rtl/burst_read_ram.sv
// burst_read_ram: append-only record buffer with fill tracking and LANES-wide grouped reads
module burst_read_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int LANES = 8,
   parameter int AF_THRESH = (1 << ADDR_WIDTH) - 1,
   localparam int RAM_DEPTH = 1 << ADDR_WIDTH,
   localparam int LW = $clog2(LANES),
   localparam int GRP_W = (ADDR_WIDTH - LW < 1) ? 1 : ADDR_WIDTH - LW
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        wr_en,
   input  logic [DATA_WIDTH-1:0]       wr_data,
   input  logic                        rd_req,
   input  logic [GRP_W-1:0]            rd_group,
   output logic                        rd_valid,
   output logic [LANES*DATA_WIDTH-1:0] rd_data,
   output logic [LANES-1:0]            rd_lane_valid,
   output logic [ADDR_WIDTH:0]         count,
   output logic                        empty,
   output logic                        full,
   output logic                        almost_full,
   output logic                        wr_overflow
);
   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [LANES*DATA_WIDTH-1:0] grp_data;
   logic [LANES-1:0] grp_valid;
   logic do_wr;
   assign full = count == (ADDR_WIDTH+1)'(RAM_DEPTH);
   assign empty = count == '0;
   assign almost_full = count >= (ADDR_WIDTH+1)'(AF_THRESH);
   assign do_wr = wr_en && !full && !clr && !rst;
   // Lane k of a group sits at record rd_group*LANES+k; indices past the array
   // (only possible when LANES == RAM_DEPTH) are never below count, so read as invalid.
   genvar k;
   for (k = 0; k < LANES; k++) begin : g_lane
      localparam logic [LW-1:0] OFF = LW'(k);
      logic [ADDR_WIDTH:0] idx;
      assign idx = (ADDR_WIDTH+1)'({rd_group, OFF});
      assign grp_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[idx[ADDR_WIDTH-1:0]];
      assign grp_valid[k] = idx < count;
   end
   // Storage is not reset; appends go to the current fill pointer.
   always_ff @(posedge clk) begin
      if (do_wr) mem[count[ADDR_WIDTH-1:0]] <= wr_data;
   end
   // Fill count and sticky overflow; clear beats a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
         wr_overflow <= 1'b0;
      end else if (wr_en) begin
         if (full) wr_overflow <= 1'b1;
         else count <= count + 1'b1;
      end
   end
   // Grouped read sees pre-edge memory and count; outputs hold between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data <= '0;
         rd_lane_valid <= '0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) begin
            rd_data <= grp_data;
            rd_lane_valid <= grp_valid;
         end
      end
   end
endmodule
